// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and control-vector helpers for the pipeline hazard sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '0;

    // Normal issue decision: a taken branch squashes IF/ID and ID/EX (and wins over a
    // load-use stall, since the stalled ID instruction is wrong-path); a load-use hazard
    // holds PC and IF/ID for one cycle and injects a bubble into ID/EX.
    function automatic pipe_ctrl_t issue_ctrl(input logic branch_taken, input logic hazard);
        pipe_ctrl_t c;
        c = CTRL_IDLE;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (hazard) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

    // Data-memory wait: freeze the whole pipe and feed a bubble into MEM/WB so the
    // instruction already in WB is not written back twice.
    function automatic pipe_ctrl_t mem_stall_ctrl();
        pipe_ctrl_t c;
        c = CTRL_IDLE;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector between EX and ID
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer with memory-wait timeout and perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;

    ctrl_state_t      state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    pipe_ctrl_t       ctrl;
    logic             fault;
    logic             hazard;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .hazard      (hazard)
    );

    // Next-state and control outputs; reset forces a quiet pipe regardless of state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = CTRL_IDLE;
        fault      = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl       = mem_stall_ctrl();
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    ctrl = issue_ctrl(ex_branch_taken, hazard);
                end
            end
            MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
                if (mem_ready) begin
                    ctrl    = issue_ctrl(ex_branch_taken, hazard);
                    state_d = RUN;
                end else begin
                    ctrl = mem_stall_ctrl();
                    if (wait_cnt_d == WC_W'(TIMEOUT - 1)) begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (reset) begin
            ctrl  = CTRL_IDLE;
            fault = 1'b0;
        end
    end

    // Saturating performance counters; FAULT cycles are deliberately not counted.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (state_q != FAULT) begin
            if (!ctrl.pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if ((ctrl.if_id_flush || ctrl.id_ex_flush) && (flush_events_q != {CNT_W{1'b1}})) begin
                flush_events_d = flush_events_q + CNT_W'(1);
            end
        end
    end

    // State, wait counter and counters; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_fault    = fault;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
    logic        if_id_flush_a, id_ex_flush_a, mem_wb_flush_a, mem_fault_a;
    logic [2:0]  stall_a, flush_a;
    logic        pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
    logic        if_id_flush_b, id_ex_flush_b, mem_wb_flush_b, mem_fault_b;
    logic [15:0] stall_b, flush_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state, index 0 = dut_a (TIMEOUT 4, 3-bit counters), 1 = dut_b (TIMEOUT 8, 16-bit)
    int m_tmo[2]  = '{4, 8};
    int m_max[2]  = '{7, 65535};
    bit m_waiting[2];
    int m_misses[2];
    bit m_faulted[2];
    int m_stalls[2];
    int m_flushes[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a),
        .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
        .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .mem_wb_flush(mem_wb_flush_a),
        .mem_fault(mem_fault_a), .stall_cycles(stall_a), .flush_events(flush_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b),
        .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
        .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .mem_wb_flush(mem_wb_flush_b),
        .mem_fault(mem_fault_b), .stall_cycles(stall_b), .flush_events(flush_b)
    );

    wire [7:0] ctrl_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                         if_id_flush_a, id_ex_flush_a, mem_wb_flush_a};
    wire [7:0] ctrl_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                         if_id_flush_b, id_ex_flush_b, mem_wb_flush_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare against the model,
    // then advance the model to what the coming rising edge should produce.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic bt,
                        input logic mq, input logic my);
        logic [7:0] exp;
        logic       exp_fault;
        bit         mem_stall, hz;
        @(negedge clk);
        reset = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = bt; mem_req = mq; mem_ready = my;
        #1;
        hz = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        for (int k = 0; k < 2; k++) begin
            string nm;
            nm = (k == 0) ? "a" : "b";
            exp = 8'b0000_0000;
            exp_fault = 1'b0;
            mem_stall = 1'b0;
            if (!r && m_faulted[k]) begin
                exp_fault = 1'b1;
            end else if (!r) begin
                mem_stall = (m_waiting[k] || mq) && !my;
                if (mem_stall)  exp = 8'b0000_0001;
                else if (bt)    exp = 8'b1111_1110;
                else if (hz)    exp = 8'b0011_1010;
                else            exp = 8'b1111_1000;
            end
            check({nm, ".ctrl"},  32'((k == 0) ? ctrl_a : ctrl_b), 32'(exp));
            check({nm, ".fault"}, 32'((k == 0) ? mem_fault_a : mem_fault_b), 32'(exp_fault));
            check({nm, ".stall_cycles"}, (k == 0) ? 32'(stall_a) : 32'(stall_b), 32'(m_stalls[k]));
            check({nm, ".flush_events"}, (k == 0) ? 32'(flush_a) : 32'(flush_b), 32'(m_flushes[k]));
            if (r) begin
                m_waiting[k] = 0; m_misses[k] = 0; m_faulted[k] = 0;
                m_stalls[k] = 0;  m_flushes[k] = 0;
            end else if (!m_faulted[k]) begin
                if (!exp[7] && m_stalls[k] < m_max[k]) m_stalls[k]++;
                if ((exp[2] || exp[1]) && m_flushes[k] < m_max[k]) m_flushes[k]++;
                if (mem_stall) begin
                    m_misses[k]++;
                    m_waiting[k] = 1;
                    if (m_misses[k] == m_tmo[k]) m_faulted[k] = 1;
                end else begin
                    m_waiting[k] = 0;
                    m_misses[k] = 0;
                end
            end
        end
    endtask

    initial begin
        int low_run;
        logic my;
        low_run = 0;
        repeat (2) @(posedge clk);

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use, then same with ex_rd = 0
        step(0, 5, 7, 5, 1, 0, 0, 0);
        step(0, 1, 2, 3, 0, 0, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0, 0);
        // branch together with load-use
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 9, 4, 9, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // memory wait: 3 stalled cycles then ready
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // zero-stall access
        step(0, 0, 0, 0, 0, 0, 1, 1);
        // timeout on dut_a, then reset recovers
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // reset during second wait cycle
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // saturation: 10 consecutive load-use stalls
        for (int i = 0; i < 10; i++) step(0, 3, 3, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (low_run > 0) begin
                my = 1'b0;
                low_run--;
            end else begin
                my = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 29) == 0) low_run = $urandom_range(2, 10);
            end
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, my);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
